// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control -- multicycle main control FSM for the 16-bit processor.
//
// Sequences every instruction through fetch / decode / execute / memory /
// writeback and drives the datapath selects and enables. FlagW, RegWA, RegWB
// and JM are raw requests; condlogic gates them with the condition result.
//
// Opcode map (Instr[15:11]):
//   0xxxx          data processing, ALU op = Instr[14:11], S bit = Instr[10]
//   10000..10101   jumps (conditional / unconditional)
//   10110          LOAD
//   10111          STORE
//   11xxx          illegal -> HALT
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-high reset (FSM -> IDLE)
//   Instr       in  16   instruction register output, used from DECODE on
//   mem_ready   in   1   memory handshake (only with MC_CTRL_WAIT_EN)
//   IRWrite     out  1   load instruction register
//   PCWrite     out  1   load PC with ALU result (PC+1)
//   AdrSrc      out  1   memory address: 0 = PC, 1 = ALUOut
//   MemWrite    out  1   data memory write strobe
//   ALUSrcA     out  1   0 = PC, 1 = register A
//   ALUSrcB     out  2   00 = reg B, 01 = immediate, 10 = constant 1
//   ResultSrc   out  2   00 = ALUOut, 01 = read data, 10 = ALU result
//   ALUControl  out  4   ALU operation, 0000 = ADD
//   FlagW       out  1   flag write request
//   RegWA       out  1   register write request, port A
//   RegWB       out  1   register write request, port B (SWAP)
//   JM          out  1   jump request
//   Halted      out  1   high while in HALT
//
// Build option:
//   MC_CTRL_WAIT_EN  when defined, FETCH, MEMRD and MEMWR stall while
//                    mem_ready is low. When undefined, mem_ready is ignored
//                    and memory is single-cycle.
// -----------------------------------------------------------------------------
module mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Instr,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  ALUControl,
  output logic        FlagW,
  output logic        RegWA,
  output logic        RegWB,
  output logic        JM,
  output logic        Halted
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXECR  = 4'd3,
    S_ALUWB  = 4'd4,
    S_JUMP   = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_CMP  = 4'b1110;
  localparam logic [3:0] ALU_SWAP = 4'b1111;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_ONE = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  state_t      state_reg;
  state_t      state_next;

  logic [4:0]  op_class;
  logic [3:0]  alu_op;
  logic        set_flags;
  logic        is_store;
  logic        mem_go;
  logic        unused_inputs;

  assign op_class  = Instr[15:11];
  assign alu_op    = Instr[14:11];
  assign set_flags = Instr[10];
  // LOAD (10110) and STORE (10111) differ only in the lowest opcode bit.
  assign is_store  = Instr[11];

  // mem_go is the "memory access completes this cycle" qualifier.
`ifdef MC_CTRL_WAIT_EN
  assign mem_go        = mem_ready;
  assign unused_inputs = ^Instr[9:0];
`else
  assign mem_go        = 1'b1;
  assign unused_inputs = ^{Instr[9:0], mem_ready};
`endif

  // ---------------------------------------------------------------------------
  // State register. Asynchronous reset so that every output (all decoded from
  // this register) drops the moment reset rises, even mid-write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
      end

      S_FETCH: begin
        if (mem_go) begin
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!op_class[4]) begin
          state_next = S_EXECR;            // 0xxxx data processing
        end else if (op_class[3]) begin
          state_next = S_HALT;             // 11xxx illegal
        end else if (op_class[2:1] == 2'b11) begin
          state_next = S_MEMADR;           // 10110 / 10111
        end else begin
          state_next = S_JUMP;             // 10000 .. 10101
        end
      end

      S_EXECR: begin
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        state_next = S_FETCH;
      end

      S_JUMP: begin
        state_next = S_FETCH;
      end

      S_MEMADR: begin
        state_next = is_store ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        if (mem_go) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        if (mem_go) begin
          state_next = S_FETCH;
        end
      end

      S_HALT: begin
        state_next = S_HALT;               // only reset leaves HALT
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs are decoded from the state register (and Instr in
  // the states that need the opcode) rather than registered separately: this
  // lets the fetch strobes follow mem_ready within the same cycle and lets
  // reset clear every output without waiting for an edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    FlagW      = 1'b0;
    RegWA      = 1'b0;
    RegWB      = 1'b0;
    JM         = 1'b0;
    Halted     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC+1 path; the strobes fire only on the cycle the fetch completes
        // so a stalled fetch does not advance the PC more than once.
        IRWrite    = mem_go;
        PCWrite    = mem_go;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_ONE;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALU;
      end

      S_EXECR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUControl = alu_op;
        FlagW      = set_flags;
      end

      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWA     = (alu_op != ALU_CMP);   // CMP only updates flags
        RegWB     = (alu_op == ALU_SWAP);  // SWAP writes both ports
      end

      S_JUMP: begin
        // Branch target = PC + imm; the actual PC load is steered by condlogic
        // via JMux, so PCWrite stays low here.
        JM         = 1'b1;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
      end

      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
      end

      S_MEMRD: begin
        AdrSrc = 1'b1;
      end

      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWA     = 1'b1;
      end

      S_MEMWR: begin
        // MemWrite is held for the whole access, including wait cycles.
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end

      S_HALT: begin
        Halted = 1'b1;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control -- randomized scoreboard bench for mc_control.
// The stimulus process walks each instruction through its phases, drives
// Instr / mem_ready per cycle and queues the output vector the phase should
// show. A negedge monitor pops and compares every cycle.
// -----------------------------------------------------------------------------
module tb_mc_control;

  logic        clk;
  logic        reset;
  logic [15:0] Instr;
  logic        mem_ready;
  logic        IRWrite, PCWrite, AdrSrc, MemWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc;
  logic [3:0]  ALUControl;
  logic        FlagW, RegWA, RegWB, JM, Halted;

  typedef struct packed {
    logic       ir;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [3:0] aluc;
    logic       fw;
    logic       rwa;
    logic       rwb;
    logic       jm;
    logic       halt;
  } outs_t;

  outs_t act;
  assign act = {IRWrite, PCWrite, AdrSrc, MemWrite, ALUSrcA, ALUSrcB, ResultSrc,
                ALUControl, FlagW, RegWA, RegWB, JM, Halted};

  mc_control dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .RegWA      (RegWA),
    .RegWB      (RegWB),
    .JM         (JM),
    .Halted     (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outs_t exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;

  task automatic check(input outs_t got, input outs_t exp, input string tag);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h required %h", tag, $time, got, exp);
    end
  endtask

  // Monitor: one expected vector per cycle while enabled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL underflow @%0t: got %h required <queued vector>", $time, act);
      end else begin
        check(act, exp_q.pop_front(), tag_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Number of cycles memory reports not-ready before completing.
  function automatic int rand_wait();
    if ($urandom_range(0, 1) == 0) return 0;
    return int'($urandom_range(1, 3));
  endfunction

  // One clock cycle of stimulus plus its expected outputs.
  task automatic step(input logic [15:0] ins, input logic mr, input outs_t e,
                      input string tag);
    @(posedge clk);
    #1;
    Instr     = ins;
    mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // A memory-touching phase: w not-ready cycles, then the completing cycle.
  // Without the wait option memory is single-cycle whatever mem_ready says.
  task automatic mem_phase(input logic [15:0] ins, input bit rand_ins, input int w,
                           input outs_t v_wait, input outs_t v_go, input string tag);
`ifdef MC_CTRL_WAIT_EN
    for (int i = 0; i < w; i++) begin
      step(rand_ins ? 16'($urandom) : ins, 1'b0, v_wait, tag);
    end
    step(rand_ins ? 16'($urandom) : ins, 1'b1, v_go, tag);
`else
    if (v_wait == v_go) begin
    end
    step(rand_ins ? 16'($urandom) : ins, (w > 0) ? 1'b0 : 1'b1, v_go, tag);
`endif
  endtask

  task automatic fetch_phase();
    outs_t vw, v;
    vw = '0;
    vw.srcb = 2'b10;
    vw.res  = 2'b10;
    v = vw;
    v.ir  = 1'b1;
    v.pcw = 1'b1;
    // Instr is garbage during FETCH; it must not matter.
    mem_phase(16'h0000, 1'b1, rand_wait(), vw, v, "FETCH");
  endtask

  // Full instruction; mw < 0 means random memory wait count.
  task automatic run_instr(input logic [15:0] ins, input int mw);
    outs_t v;
    int    w;
    int    op5;
    logic [3:0] op;
    op5 = int'(ins[15:11]);
    op  = ins[14:11];
    $display("instr %04h class %05b", ins, ins[15:11]);
    fetch_phase();
    step(ins, rbit(), '0, "DECODE");
    if (op5 < 16) begin
      v = '0; v.srca = 1'b1; v.aluc = op; v.fw = ins[10];
      step(ins, rbit(), v, "EXECR");
      v = '0; v.rwa = (op != 4'd14); v.rwb = (op == 4'd15);
      step(ins, rbit(), v, "ALUWB");
    end else if (op5 <= 21) begin
      v = '0; v.jm = 1'b1; v.srcb = 2'b01;
      step(ins, rbit(), v, "JUMP");
    end else if (op5 <= 23) begin
      v = '0; v.srca = 1'b1; v.srcb = 2'b01;
      step(ins, rbit(), v, "MEMADR");
      w = (mw < 0) ? rand_wait() : mw;
      if (op5 == 22) begin
        v = '0; v.adr = 1'b1;
        mem_phase(ins, 1'b0, w, v, v, "MEMRD");
        v = '0; v.res = 2'b01; v.rwa = 1'b1;
        step(ins, rbit(), v, "MEMWB");
      end else begin
        v = '0; v.adr = 1'b1; v.mw = 1'b1;
        mem_phase(ins, 1'b0, w, v, v, "MEMWR");
      end
    end else begin
      v = '0; v.halt = 1'b1;
      for (int i = 0; i < 6; i++) step(ins, rbit(), v, "HALT");
    end
  endtask

  // Raise reset mid-cycle, check outputs clear at once, then release so the
  // next cycle is IDLE and FETCH follows.
  task automatic async_reset_and_release(input string tag);
    reset = 1'b1;
    #1;
    check(act, '0, tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    Instr = 16'($urandom);
    exp_q.push_back('0);
    tag_q.push_back("IDLE");
    mon_en = 1'b1;
  endtask

  logic [15:0] rins;
  outs_t       vpre;

  initial begin
    reset     = 1'b1;
    Instr     = 16'h0000;
    mem_ready = 1'b1;
    #13;
    check(act, '0, "RESET");
    async_reset_and_release("RESET_HOLD");

    run_instr(16'h0400, -1);   // ADD, S=1
    run_instr(16'h7400, -1);   // CMP, S=1
    run_instr(16'h7800, -1);   // SWAP
    run_instr(16'h8000, -1);   // JE
    run_instr(16'hB000, 2);    // LOAD, two not-ready cycles in MEMRD
    run_instr(16'hB800, 1);    // STORE, one not-ready cycle in MEMWR

    for (int n = 0; n < 80; n++) begin
      rins = 16'($urandom);
      if (rins[15:14] == 2'b11) rins[14] = 1'b0;   // keep illegal ops out
      run_instr(rins, -1);
    end

    // STORE interrupted by reset in MEMWR.
    rins = 16'hB823;
    $display("instr %04h store cut by reset", rins);
    fetch_phase();
    step(rins, rbit(), '0, "DECODE");
    vpre = '0; vpre.srca = 1'b1; vpre.srcb = 2'b01;
    step(rins, rbit(), vpre, "MEMADR");
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mon_en    = 1'b0;
    #2;
    vpre = '0; vpre.adr = 1'b1; vpre.mw = 1'b1;
    check(act, vpre, "MEMWR_PRE");
    async_reset_and_release("MEMWR_RESET");

    for (int n = 0; n < 5; n++) begin
      rins = 16'($urandom);
      rins[15] = 1'b0;
      run_instr(rins, -1);
    end

    // Illegal opcode: HALT holds until reset.
    run_instr(16'hC000, -1);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    vpre = '0; vpre.halt = 1'b1;
    #1;
    check(act, vpre, "HALT_PRE");
    async_reset_and_release("HALT_RESET");

    run_instr(16'h0000, -1);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d left required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
